double_to_unsint: RTL and testbench
===================================

Name: double_to_unsint

Overview:
- Multi-cycle converter from IEEE-754 binary64 to a 32-bit unsigned integer, rounding toward zero (truncation).
- Sits in the FPU conversion path, downstream of double-producing stages. It consumes the 64-bit result word and returns an integer to the integer datapath.
- Uses the same en/complete handshake as the other FPU conversion blocks.
- Out-of-range inputs saturate and raise an exception flag.

Parameters:
- None. Widths are fixed: 64-bit input, 32-bit output.

Ports:
- clk       input   1   clock
- rst       input   1   reset, synchronous, active-high
- en        input   1   enable; while high, the block converts input_a back-to-back
- input_a   input   64  binary64 operand; sampled in GET_A
- output_z  output  32  unsigned integer result; held until the next PUT_Z
- complete  output  1   one-cycle pulse; output_z and the flags are valid in that cycle
- invalid   output  1   NaN, negative value ≤ -1.0, or overflow; valid with complete
- inexact   output  1   nonzero fraction bits were discarded; valid with complete

Behaviour:
- Reset and enable:
  - rst=1 at a clock edge: state←GET_A; output_z, complete, invalid and inexact ←0. rst has priority over en.
  - rst mid-conversion aborts the conversion; no complete is issued.
  - en=0 (and rst=0): same clearing as rst, state←GET_A, and the block ignores input_a.
- Field decode: s=a[63]; E=a[62:52]; f=a[51:0]; unbiased exponent e=E-1023 (signed, 12 bits).
- States: GET_A → UNPACK → {LOAD → ALIGN* → PUT_Z | PUT_Z} → GET_A.
- GET_A: a←input_a; complete←0; next UNPACK.
- UNPACK: classify and go to PUT_Z directly with result r and flags as follows:
  - E=2047, f≠0 (NaN): r=0, invalid=1.
  - E=2047, f=0, s=0 (+inf): r=32'hFFFFFFFF, invalid=1.
  - E=2047, f=0, s=1 (-inf): r=0, invalid=1.
  - E=0 (±zero or denormal): r=0, invalid=0, inexact=(f≠0).
  - e<0 (|a|<1.0, either sign): r=0, invalid=0, inexact=1.
  - s=1 with e≥0: r=0, invalid=1, inexact=0.
  - s=0 with e>31: r=32'hFFFFFFFF, invalid=1, inexact=0.
  - Otherwise (s=0, 0≤e≤31): next LOAD.
- LOAD:
  - r←{1'b1,f[51:21]}
  - cnt←31-e (5 bits)
  - sticky←|f[20:0]
  - next ALIGN.
- ALIGN:
  - If cnt≠0: sticky←sticky|r[0]; r←r>>1; cnt←cnt-1; stay.
  - If cnt=0: next PUT_Z.
- PUT_Z:
  - output_z←r; invalid←flag; inexact←sticky (or the UNPACK value); complete←1.
  - next GET_A.
- Latency, counted as edges from the GET_A sampling edge (edge 1) to the edge that sets complete:
  - Special/short path: edge 3.
  - Normal path: edge 36-e, so 5 for e=31 and 36 for e=0.
- Throughput: while en stays high, the next GET_A follows PUT_Z immediately. complete is high for exactly one cycle per conversion.
- Result and flag registers:
  - output_z and the flags hold their values between completions; they change only at PUT_Z, rst or en=0.
  - The internal r, cnt, sticky and flag registers are cleared in GET_A, so no stale flags carry into the next result.
- Input timing: input_a may change at any time. Only the value present at the GET_A edge is used.

Decomposition:
- Shared package fpu_conv_pkg holds:
  - state encoding (3-bit: GET_A, UNPACK, LOAD, ALIGN, PUT_Z)
  - DBL_BIAS=1023, DBL_EXP_W=11, DBL_FRAC_W=52, EXP_ALL_ONES
  - saturation constant UINT32_MAX
- Optional sub-module dbl_unpack: purely combinational. Outputs sign, unbiased exponent, fraction, is_nan, is_inf, is_zero_or_denorm. Other FPU conversion blocks can reuse it.
- FSM and shifter stay in the top module.

Test Plan:
- 0x3FF0000000000000 (1.0) → output_z=1, invalid=0, inexact=0, complete at edge 36.
- 0x41EFFFFFFFE00000 (4294967295.0) → output_z=0xFFFFFFFF, flags 0, complete at edge 5.
- 0x400E000000000000 (3.75) → output_z=3, inexact=1, invalid=0, complete at edge 35.
- Special operands, each complete at edge 3:
  - 0x41F0000000000000 (2^32) → 0xFFFFFFFF, invalid=1.
  - 0xC000000000000000 (-2.0) → 0, invalid=1.
  - 0x7FF8000000000000 (NaN) → 0, invalid=1.
  - 0xBFE0000000000000 (-0.5) → 0, inexact=1, invalid=0.
- Abort: start a conversion of 1.0 and assert rst at edge 10 → no complete; all outputs 0 next cycle. After release, 0x4059000000000000 (100.0) → 100.
- Back-to-back: hold en=1 with a random stream of 2000 values in [0, 2^32+2^20] → each completion matches the truncation model, one complete pulse per operand. en dropped mid-conversion → outputs 0 and the conversion restarts in GET_A.

Source files
------------

// File: rtl/fpu_conv_pkg.sv
// Shared definitions for the FPU conversion blocks.
// Contents:
//   conv_state_t : 3-bit state encoding used by the en/complete converters
//   DBL_*        : binary64 field geometry and exponent bias
//   EXP_ALL_ONES : biased exponent value reserved for inf/NaN
//   UINT32_MAX   : saturation value for unsigned 32-bit results
package fpu_conv_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    UNPACK = 3'd1,
    LOAD   = 3'd2,
    ALIGN  = 3'd3,
    PUT_Z  = 3'd4
  } conv_state_t;

  localparam int DBL_BIAS   = 1023;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;

  localparam logic [DBL_EXP_W-1:0] EXP_ALL_ONES = '1;
  localparam logic [31:0]          UINT32_MAX   = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbl_unpack.sv
// Combinational binary64 field decoder, shared by the conversion blocks.
// Ports:
//   a                 : binary64 operand
//   sign              : a[63]
//   exp_unb           : unbiased exponent E-1023, signed, 12 bits
//   frac              : stored fraction a[51:0]
//   is_nan            : E all ones, fraction nonzero
//   is_inf            : E all ones, fraction zero
//   is_zero_or_denorm : E zero (signed zero or subnormal)
module dbl_unpack
  import fpu_conv_pkg::*;
(
  input  logic [63:0]                  a,
  output logic                         sign,
  output logic signed [DBL_EXP_W:0]    exp_unb,
  output logic [DBL_FRAC_W-1:0]        frac,
  output logic                         is_nan,
  output logic                         is_inf,
  output logic                         is_zero_or_denorm
);

  logic [DBL_EXP_W-1:0] exp_raw;
  logic                 frac_nz;

  assign sign    = a[63];
  assign exp_raw = a[62:52];
  assign frac    = a[51:0];
  assign frac_nz = |frac;

  // Zero-extend before subtracting so every biased value maps into
  // -1023..1024 without wrapping.
  assign exp_unb = $signed({1'b0, exp_raw} - 12'(DBL_BIAS));

  assign is_nan            = (exp_raw == EXP_ALL_ONES) &&  frac_nz;
  assign is_inf            = (exp_raw == EXP_ALL_ONES) && !frac_nz;
  assign is_zero_or_denorm = (exp_raw == '0);

endmodule

// File: rtl/double_to_unsint.sv
// binary64 -> unsigned 32-bit integer converter, truncating toward zero.
// Multi-cycle: the mantissa is right-aligned one bit per cycle, so the
// normal-path latency depends on the exponent.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : enable; low clears the block and holds it in GET_A
//   input_a   : binary64 operand, sampled in GET_A
//   output_z  : integer result, held between completions
//   complete  : one-cycle pulse when output_z/flags are updated
//   invalid   : NaN, value <= -1.0, or value >= 2^32
//   inexact   : nonzero fraction bits were discarded
module double_to_unsint
  import fpu_conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] input_a,
  output logic [31:0] output_z,
  output logic        complete,
  output logic        invalid,
  output logic        inexact
);

  conv_state_t state;

  logic [63:0] a;
  logic [31:0] r;
  logic [4:0]  cnt;
  logic        sticky;
  logic        flag;

  logic                      sign;
  logic signed [DBL_EXP_W:0] exp_unb;
  logic [DBL_FRAC_W-1:0]     frac;
  logic                      is_nan;
  logic                      is_inf;
  logic                      is_zero_or_denorm;

  dbl_unpack u_unpack (
    .a                 (a),
    .sign              (sign),
    .exp_unb           (exp_unb),
    .frac              (frac),
    .is_nan            (is_nan),
    .is_inf            (is_inf),
    .is_zero_or_denorm (is_zero_or_denorm)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      // Disable behaves like reset so a dropped enable never leaves a
      // half-finished conversion or stale flags behind.
      state    <= GET_A;
      a        <= '0;
      r        <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      flag     <= 1'b0;
      output_z <= '0;
      complete <= 1'b0;
      invalid  <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          a        <= input_a;
          r        <= '0;
          cnt      <= '0;
          sticky   <= 1'b0;
          flag     <= 1'b0;
          complete <= 1'b0;
          state    <= UNPACK;
        end

        UNPACK: begin
          // Classification order matters: inf/NaN share the all-ones
          // exponent and must be caught before any range test.
          state <= PUT_Z;
          if (is_nan) begin
            r    <= '0;
            flag <= 1'b1;
          end else if (is_inf) begin
            r    <= sign ? 32'd0 : UINT32_MAX;
            flag <= 1'b1;
          end else if (is_zero_or_denorm) begin
            r      <= '0;
            sticky <= |frac;
          end else if (exp_unb < 12'sd0) begin
            // |a| < 1.0: truncates to zero for either sign, never invalid.
            r      <= '0;
            sticky <= 1'b1;
          end else if (sign) begin
            r    <= '0;
            flag <= 1'b1;
          end else if (exp_unb > 12'sd31) begin
            r    <= UINT32_MAX;
            flag <= 1'b1;
          end else begin
            state <= LOAD;
          end
        end

        LOAD: begin
          // Hidden bit at r[31]; a value with e=31 needs no shift. Fraction
          // bits below the 32-bit window only feed the sticky bit.
          r      <= {1'b1, frac[51:21]};
          cnt    <= 5'd31 - exp_unb[4:0];
          sticky <= |frac[20:0];
          state  <= ALIGN;
        end

        ALIGN: begin
          if (cnt != 5'd0) begin
            sticky <= sticky | r[0];
            r      <= r >> 1;
            cnt    <= cnt - 5'd1;
          end else begin
            state <= PUT_Z;
          end
        end

        PUT_Z: begin
          output_z <= r;
          invalid  <= flag;
          inexact  <= sticky;
          complete <= 1'b1;
          state    <= GET_A;
        end

        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_double_to_unsint.sv
module tb_double_to_unsint;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] input_a;
  logic [31:0] output_z;
  logic        complete;
  logic        invalid;
  logic        inexact;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] prev_z;
  logic        prev_inv;
  logic        prev_inex;

  double_to_unsint dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .input_a  (input_a),
    .output_z (output_z),
    .complete (complete),
    .invalid  (invalid),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: truncation computed on the real value itself.
  task automatic model(input logic [63:0] op, output logic [31:0] z,
                       output logic inv, output logic inex, output int lat);
    real    x;
    real    t;
    real    p;
    int     k;
    longint li;
    x = $bitstoreal(op);
    z = '0; inv = 1'b0; inex = 1'b0; lat = 3;
    if (x != x) begin
      inv = 1'b1;
    end else if (x >= 4294967296.0) begin
      z = 32'hFFFF_FFFF; inv = 1'b1;
    end else if (x <= -1.0) begin
      inv = 1'b1;
    end else if (x < 1.0) begin
      inex = (x != 0.0);
    end else begin
      t    = $floor(x);
      li   = longint'(t);
      z    = li[31:0];
      inex = (t != x);
      k = 0; p = 2.0;
      while (p <= x) begin
        p = p * 2.0;
        k++;
      end
      lat = 36 - k;
    end
  endtask

  // Called just after a negedge with the DUT in GET_A. Returns at the
  // negedge where complete is seen; lat=0 means it never came.
  task automatic run_op(input logic [63:0] op, output logic [31:0] z,
                        output logic inv, output logic inex, output int lat,
                        output logic [31:0] held);
    input_a = op;
    lat = 0; z = '0; inv = 1'b0; inex = 1'b0; held = '0;
    for (int n = 1; n <= 64 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        held    = output_z;
        input_a = {$urandom, $urandom};
      end
      if (complete) begin
        lat = n; z = output_z; inv = invalid; inex = inexact;
      end
    end
  endtask

  task automatic dir(input string tag, input logic [63:0] op, input logic [31:0] ez,
                     input logic ei, input logic ex, input int elat);
    logic [31:0] z, held;
    logic        inv, inex;
    int          lat;
    run_op(op, z, inv, inex, lat, held);
    chk({tag, "_z"},    z, ez);
    chk({tag, "_inv"},  inv, ei);
    chk({tag, "_inex"}, inex, ex);
    chk({tag, "_lat"},  lat, elat);
    chk({tag, "_hold"}, held, prev_z);
    prev_z = z;
  endtask

  function automatic logic [63:0] rand_op();
    int          sel;
    int          sh;
    logic [31:0] u;
    real         x;
    sel = $urandom_range(0, 15);
    u   = $urandom;
    if (sel == 0) begin
      x = 4294967296.0 + real'($urandom_range(0, 1 << 20));
    end else if (sel == 1) begin
      x = real'(u) / 4294967296.0;
    end else if (sel == 2) begin
      x = 4294967295.0 - real'($urandom_range(0, 3)) + real'($urandom_range(0, 1)) * 0.5;
    end else begin
      x  = real'(u);
      sh = $urandom_range(0, 31);
      repeat (sh) x = x / 2.0;
    end
    return $realtobits(x);
  endfunction

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] z, held, mz;
    logic        inv, inex, mi, mx;
    int          lat, mlat;
    int          pulses;

    rst = 1'b1; en = 1'b0; input_a = 64'h3FF0_0000_0000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_z", output_z, 32'd0);
    chk("rst_complete", complete, 1'b0);
    chk("rst_inv", invalid, 1'b0);
    chk("rst_inex", inexact, 1'b0);
    rst = 1'b0; en = 1'b1;
    prev_z = '0;

    dir("one",    64'h3FF0_0000_0000_0000, 32'd1,           1'b0, 1'b0, 36);
    dir("umax",   64'h41EF_FFFF_FFE0_0000, 32'hFFFF_FFFF,   1'b0, 1'b0, 5);
    dir("p2_32",  64'h41F0_0000_0000_0000, 32'hFFFF_FFFF,   1'b1, 1'b0, 3);
    dir("neg2",   64'hC000_0000_0000_0000, 32'd0,           1'b1, 1'b0, 3);
    dir("nan",    64'h7FF8_0000_0000_0000, 32'd0,           1'b1, 1'b0, 3);
    dir("pinf",   64'h7FF0_0000_0000_0000, 32'hFFFF_FFFF,   1'b1, 1'b0, 3);
    dir("ninf",   64'hFFF0_0000_0000_0000, 32'd0,           1'b1, 1'b0, 3);
    dir("negh",   64'hBFE0_0000_0000_0000, 32'd0,           1'b0, 1'b1, 3);
    dir("nzero",  64'h8000_0000_0000_0000, 32'd0,           1'b0, 1'b0, 3);
    dir("denorm", 64'h0000_0000_0000_0001, 32'd0,           1'b0, 1'b1, 3);
    dir("neg1",   64'hBFF0_0000_0000_0000, 32'd0,           1'b1, 1'b0, 3);
    dir("f375",   64'h400E_0000_0000_0000, 32'd3,           1'b0, 1'b1, 35);

    // Reset at edge 10 of a 1.0 conversion.
    input_a = 64'h3FF0_0000_0000_0000;
    pulses = 0;
    repeat (9) begin
      @(posedge clk); @(negedge clk);
      if (complete) pulses++;
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_z", output_z, 32'd0);
    chk("abort_complete", complete, 1'b0);
    chk("abort_inex", inexact, 1'b0);
    chk("abort_inv", invalid, 1'b0);
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (complete) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    rst = 1'b0;
    prev_z = '0;
    dir("hundred", 64'h4059_0000_0000_0000, 32'd100, 1'b0, 1'b0, 30);

    // Drop enable mid-conversion, then confirm a clean restart.
    input_a = 64'h3FF0_0000_0000_0000;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("endrop_z", output_z, 32'd0);
    chk("endrop_complete", complete, 1'b0);
    en = 1'b1;
    prev_z = '0;
    dir("restart", 64'h400E_0000_0000_0000, 32'd3, 1'b0, 1'b1, 35);

    for (int i = 0; i < 2000; i++) begin
      logic [63:0] op;
      op = rand_op();
      model(op, mz, mi, mx, mlat);
      run_op(op, z, inv, inex, lat, held);
      chk("rnd_z",    z, mz);
      chk("rnd_inv",  inv, mi);
      chk("rnd_inex", inex, mx);
      chk("rnd_lat",  lat, mlat);
      chk("rnd_hold", held, prev_z);
      prev_z = z;
    end

    // After the last completion the pulse must drop on the next edge.
    @(posedge clk); @(negedge clk);
    chk("pulse_width", complete, 1'b0);
    chk("final_hold", output_z, prev_z);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
